// File: rtl/mem_ctrl_pkg.sv
// Shared defaults, burst limits and FSM state encoding for the mem_ctrl burst controller.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_BEATS  = 8;
  localparam int LEN_W      = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_t;

endpackage

// File: rtl/mem_ctrl_addr_gen.sv
// Burst address/beat tracker: load on accept, step per issued beat, flag the final beat.
module mem_ctrl_addr_gen
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W-1:0] o_addr_inc,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;

  // Increment wraps naturally at 2^ADDR_W.
  assign o_addr_inc = r_addr + ADDR_W'(1);
  assign o_addr     = r_addr;
  assign o_last     = (r_remain == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (i_load) begin
      r_addr   <= i_addr;
      r_remain <= i_len;
    end else if (i_step) begin
      r_addr   <= o_addr_inc;
      r_remain <= r_remain - LEN_W'(1);
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port RAM burst controller (1..8 beats, registered RAM-side outputs).
// Define MEM_BOUNDS_CHECK_EN to reject bursts that would run past the top address.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state, w_state_next;
  logic              r_mem_read, r_mem_write, r_rd_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_rd_data;

  logic              w_mem_read_next, w_mem_write_next;
  logic [ADDR_W-1:0] w_mem_addr_next;
  logic [DATA_W-1:0] w_mem_wdata_next;
  logic              w_load, w_step, w_reject, w_done;
  logic [ADDR_W-1:0] w_gen_addr, w_gen_addr_inc;
  logic              w_gen_last;

  mem_ctrl_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clock     (clock),
    .resetn    (resetn),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_addr    (req_addr),
    .i_len     (req_len),
    .o_addr    (w_gen_addr),
    .o_addr_inc(w_gen_addr_inc),
    .o_last    (w_gen_last)
  );

  // A write burst lingers in FINISH while its final mem_write is on the bus,
  // so done lands in the cycle after the last RAM write.
  assign w_done    = (r_state == S_FINISH) && !r_mem_write;
  assign done      = w_done;
  assign req_ready = (r_state == S_IDLE);
  assign wr_ready  = (r_state == S_WRITE);
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

`ifdef MEM_BOUNDS_CHECK_EN
  logic [ADDR_W:0] w_end_addr;
  logic            r_reject;

  // Carry out of the last-beat address means the burst would cross the top.
  assign w_end_addr = {1'b0, req_addr} + (ADDR_W + 1)'(req_len);
  assign w_reject   = w_end_addr[ADDR_W];
  assign err        = w_done && r_reject;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_reject <= 1'b0;
    end else if (w_load) begin
      r_reject <= w_reject;
    end
  end
`else
  assign w_reject = 1'b0;
  assign err      = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_mem_read_next  = 1'b0;
    w_mem_write_next = 1'b0;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_load           = 1'b0;
    w_step           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_load = 1'b1;
          if (w_reject) begin
            w_state_next = S_FINISH;
          end else if (req_write) begin
            w_state_next = S_WRITE;
          end else begin
            w_state_next    = S_READ;
            w_mem_read_next = 1'b1;
            w_mem_addr_next = req_addr;
          end
        end
      end
      S_READ: begin
        if (w_gen_last) begin
          w_state_next = S_FINISH;
        end else begin
          w_step          = 1'b1;
          w_mem_read_next = 1'b1;
          w_mem_addr_next = w_gen_addr_inc;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          w_mem_write_next = 1'b1;
          w_mem_addr_next  = w_gen_addr;
          w_mem_wdata_next = wr_data;
          if (w_gen_last) begin
            w_state_next = S_FINISH;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      S_FINISH: begin
        if (!r_mem_write) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_read  <= w_mem_read_next;
      r_mem_write <= w_mem_write_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      // RAM returns data by the end of the issue cycle; present it one cycle later.
      r_rd_valid  <= r_mem_read;
      if (r_mem_read) begin
        r_rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed burst table, hand-written corner sequences
// and random bursts checked against an array-based memory model.
module tb_mem_ctrl;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [2:0]  req_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_ctrl dut (
    .clock    (clock),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .done     (done),
    .err      (err),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i >= 16 && i <= 19) return 32'hA0 + 32'(i - 16);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // RAM samples its controls on the falling edge; read data is registered.
  logic [31:0] ram [512];
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 512; i++) ram[i] = init_word(i);
    forever begin
      @(negedge clock);
      if (mem_read)  mem_rdata = ram[mem_addr];
      if (mem_write) ram[mem_addr] = mem_wdata;
    end
  end

  // Event log sampled mid-cycle.
  int          cyc = 0;
  int          both_cnt = 0;
  int          rd_cyc_q[$], rv_cyc_q[$], wr_cyc_q[$], done_cyc_q[$], err_cyc_q[$], acc_cyc_q[$];
  logic [8:0]  rd_addr_q[$], wr_addr_q[$];
  logic [31:0] rv_data_q[$], wr_data_q[$];

  always @(negedge clock) begin
    cyc++;
    if (mem_read)  begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(mem_addr); end
    if (rd_valid)  begin rv_cyc_q.push_back(cyc); rv_data_q.push_back(rd_data); end
    if (mem_write) begin wr_cyc_q.push_back(cyc); wr_addr_q.push_back(mem_addr); wr_data_q.push_back(mem_wdata); end
    if (done)      done_cyc_q.push_back(cyc);
    if (err)       err_cyc_q.push_back(cyc);
    if (req_valid && req_ready) acc_cyc_q.push_back(cyc);
    if (mem_read && mem_write) both_cnt++;
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] model_mem [512];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [2:0]  len;
    int          gap;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          exp_err;
    int          exp_acc;
  } vec_t;

  task automatic run_burst(input string tag, input vec_t v);
    int          rd_b, rv_b, wr_b, dn_b, er_b, ac_b, nb;
    int          n_rd, n_rv, n_wr;
    logic [31:0] wd [8];
    bit          ok;
    nb = int'(v.len) + 1;
    for (int i = 0; i < 8; i++)
      wd[i] = (i == 0) ? v.d0 : (i == 1) ? v.d1 : v.d0 + 32'(i) * 32'h0101_0101;
    rd_b = rd_cyc_q.size(); rv_b = rv_cyc_q.size(); wr_b = wr_cyc_q.size();
    dn_b = done_cyc_q.size(); er_b = err_cyc_q.size(); ac_b = acc_cyc_q.size();

    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len;
    tick();
    req_valid = 1'b0;
    if (v.wr) begin
      for (int i = 0; i < nb; i++) begin
        wr_valid = 1'b1; wr_data = wd[i];
        tick();
        wr_valid = 1'b0;
        repeat (v.gap) tick();
      end
    end
    for (int k = 0; k < 64 && done_cyc_q.size() == dn_b; k++) tick();
    repeat (3) tick();

    n_rd = rd_cyc_q.size() - rd_b;
    n_rv = rv_cyc_q.size() - rv_b;
    n_wr = wr_cyc_q.size() - wr_b;
    check({tag, "_accept"}, 64'(acc_cyc_q.size() - ac_b), 64'(1));
    check({tag, "_done"},   64'(done_cyc_q.size() - dn_b), 64'(1));
    check({tag, "_err"},    64'(err_cyc_q.size() - er_b), 64'(v.exp_err));
    check({tag, "_access"}, 64'(n_rd + n_wr), 64'(v.exp_acc));
    if (v.exp_err && done_cyc_q.size() > dn_b && err_cyc_q.size() > er_b)
      check({tag, "_err_with_done"}, 64'(err_cyc_q[er_b]), 64'(done_cyc_q[dn_b]));

    if (!v.wr && v.exp_acc > 0 && n_rd == v.exp_acc && n_rv == v.exp_acc
        && done_cyc_q.size() > dn_b) begin
      ok = 1'b1;
      for (int i = 0; i < n_rd; i++) begin
        check({tag, "_rd_addr"}, 64'(rd_addr_q[rd_b + i]), 64'(9'(v.addr + 9'(i))));
        check({tag, "_rd_data"}, 64'(rv_data_q[rv_b + i]), 64'(model_mem[9'(v.addr + 9'(i))]));
        if (rd_cyc_q[rd_b + i] != acc_cyc_q[ac_b] + 1 + i) ok = 1'b0;
        if (rv_cyc_q[rv_b + i] != rd_cyc_q[rd_b + i] + 1) ok = 1'b0;
      end
      check({tag, "_rd_timing"}, 64'(ok), 64'(1));
      check({tag, "_rd_done_cyc"}, 64'(done_cyc_q[dn_b]), 64'(rv_cyc_q[rv_b + n_rv - 1]));
    end

    if (v.wr && v.exp_acc > 0 && n_wr == v.exp_acc && done_cyc_q.size() > dn_b) begin
      for (int i = 0; i < n_wr; i++) begin
        check({tag, "_wr_addr"}, 64'(wr_addr_q[wr_b + i]), 64'(9'(v.addr + 9'(i))));
        check({tag, "_wr_data"}, 64'(wr_data_q[wr_b + i]), 64'(wd[i]));
      end
      check({tag, "_wr_done_cyc"}, 64'(done_cyc_q[dn_b]), 64'(wr_cyc_q[wr_b + n_wr - 1] + 1));
    end

    if (v.wr && v.exp_acc > 0)
      for (int i = 0; i < nb; i++) model_mem[9'(v.addr + 9'(i))] = wd[i];
  endtask

  vec_t vecs [8];

  initial begin
    int   wr_b, dn_b, ac_b, rd_b;
    vec_t rv;
    vec_t clean;
    bit   rej;

    vecs[0] = '{1'b0, 9'h010, 3'd3, 0, 32'h0, 32'h0, 1'b0, 4};
    vecs[1] = '{1'b1, 9'h020, 3'd1, 2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 2};
    vecs[2] = '{1'b0, 9'h020, 3'd1, 0, 32'h0, 32'h0, 1'b0, 2};
    vecs[3] = '{1'b0, 9'h1FE, 3'd3, 0, 32'h0, 32'h0, BC, BC ? 0 : 4};
    vecs[4] = '{1'b1, 9'h1FF, 3'd1, 0, 32'hAAAA_0001, 32'hAAAA_0002, BC, BC ? 0 : 2};
    vecs[5] = '{1'b0, 9'h1FF, 3'd0, 0, 32'h0, 32'h0, 1'b0, 1};
    vecs[6] = '{1'b0, 9'h1F8, 3'd7, 0, 32'h0, 32'h0, 1'b0, 8};
    vecs[7] = '{1'b0, 9'h000, 3'd1, 0, 32'h0, 32'h0, 1'b0, 2};

    for (int i = 0; i < 512; i++) model_mem[i] = init_word(i);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;

    resetn = 1'b1;
    #2 resetn = 1'b0;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_done",      64'(done), 64'(0));
    check("rst_err",       64'(err), 64'(0));
    check("rst_rd_valid",  64'(rd_valid), 64'(0));
    check("rst_mem_read",  64'(mem_read), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_mem_addr",  64'(mem_addr), 64'(0));
    check("rst_wr_ready",  64'(wr_ready), 64'(0));
    repeat (3) tick();
    resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_burst($sformatf("vec%0d", i), vecs[i]);

    // Reset lands while the second beat of an 8-beat write is on the RAM bus.
    wr_b = wr_cyc_q.size(); dn_b = done_cyc_q.size();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h100; req_len = 3'd7;
    tick();
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h5555_0000;
    tick();
    wr_data = 32'h5555_0001;
    tick();
    wr_valid = 1'b0;
    check("midrst_mem_write_before", 64'(mem_write), 64'(1));
    resetn = 1'b0;
    #1;
    check("midrst_mem_write_after", 64'(mem_write), 64'(0));
    check("midrst_req_ready",       64'(req_ready), 64'(1));
    repeat (2) tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("midrst_writes", 64'(wr_cyc_q.size() - wr_b), 64'(1));
    check("midrst_no_done", 64'(done_cyc_q.size() - dn_b), 64'(0));
    model_mem[9'h100] = 32'h5555_0000;
    clean = '{1'b0, 9'h100, 3'd1, 0, 32'h0, 32'h0, 1'b0, 2};
    run_burst("post_rst", clean);

    // req_valid held high across a burst: the next request waits for the IDLE cycle after done.
    ac_b = acc_cyc_q.size(); dn_b = done_cyc_q.size(); rd_b = rd_cyc_q.size();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h040; req_len = 3'd3;
    tick();
    req_addr = 9'h050; req_len = 3'd1;
    for (int k = 0; k < 64 && done_cyc_q.size() - dn_b < 2; k++) tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("hold_accepts", 64'(acc_cyc_q.size() - ac_b), 64'(2));
    check("hold_dones",   64'(done_cyc_q.size() - dn_b), 64'(2));
    check("hold_reads",   64'(rd_cyc_q.size() - rd_b), 64'(6));
    if (acc_cyc_q.size() - ac_b >= 2 && done_cyc_q.size() > dn_b)
      check("hold_second_accept_cyc", 64'(acc_cyc_q[ac_b + 1]), 64'(done_cyc_q[dn_b] + 1));
    if (rd_cyc_q.size() - rd_b >= 5)
      check("hold_second_addr", 64'(rd_addr_q[rd_b + 4]), 64'(9'h050));

    for (int n = 0; n < 24; n++) begin
      rv.wr   = 1'($urandom_range(0, 1));
      rv.addr = ($urandom_range(0, 3) == 0) ? 9'(32'h1F8 + $urandom_range(0, 7)) : 9'($urandom());
      rv.len  = 3'($urandom_range(0, 7));
      rv.gap  = int'($urandom_range(0, 2));
      rv.d0   = $urandom();
      rv.d1   = $urandom();
      rej     = BC && (int'(rv.addr) + int'(rv.len) > 511);
      rv.exp_err = rej;
      rv.exp_acc = rej ? 0 : int'(rv.len) + 1;
      run_burst($sformatf("rnd%0d", n), rv);
    end

    check("never_read_and_write", 64'(both_cnt), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
